// File: rtl/video_timing_gen.sv
// video_timing_gen: 15 kHz RGB333 raster with bitmap fetch, pixel shifter, border/blank and syncs; CSYNC_EN adds csync_n.
// Latency: colour, syncs and frame trail the counter pixel by 1 clock; fb_rd/fb_addr registered, read data expected the next cycle.
// Backpressure: none; the framebuffer must answer every strobe with a fixed 1-cycle latency.
module video_timing_gen #(
    parameter int H_TOTAL       = 416,
    parameter int H_BLANK_START = 320,
    parameter int H_BLANK_END   = 400,
    parameter int H_SYNC_START  = 336,
    parameter int H_SYNC_LEN    = 32,
    parameter int V_TOTAL       = 312,
    parameter int V_BLANK_START = 248,
    parameter int V_BLANK_END   = 264,
    parameter int V_SYNC_START  = 248,
    parameter int V_SYNC_LEN    = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [8:0]  ink,
    input  logic [8:0]  paper,
    input  logic [8:0]  border,
    output logic        fb_rd,
    output logic [12:0] fb_addr,
    input  logic [7:0]  fb_data,
    output logic [2:0]  ro,
    output logic [2:0]  go,
    output logic [2:0]  bo,
    output logic        hsync_n,
    output logic        vsync_n,
    output logic        frame
`ifdef CSYNC_EN
    ,
    output logic        csync_n
`endif
);

    localparam logic [8:0] HC_LAST = 9'(H_TOTAL - 1);
    localparam logic [8:0] HC_PRE  = 9'(H_TOTAL - 2);
    localparam logic [8:0] VC_LAST = 9'(V_TOTAL - 1);
    localparam logic [8:0] HB_S    = 9'(H_BLANK_START);
    localparam logic [8:0] HB_E    = 9'(H_BLANK_END);
    localparam logic [8:0] HS_S    = 9'(H_SYNC_START);
    localparam logic [8:0] HS_E    = 9'(H_SYNC_START + H_SYNC_LEN);
    localparam logic [8:0] VB_S    = 9'(V_BLANK_START);
    localparam logic [8:0] VB_E    = 9'(V_BLANK_END);
    localparam logic [8:0] VS_S    = 9'(V_SYNC_START);
    localparam logic [8:0] VS_E    = 9'(V_SYNC_START + V_SYNC_LEN);

    logic [8:0]  hc_q, hc_d, vc_q, vc_d, next_vc;
    logic [4:0]  grp;
    logic [7:0]  shift_q, shift_d;
    logic [8:0]  rgb_q, rgb_d;
    logic        hs_q, hs_d, vs_q, vs_d;
    logic        frame_q, frame_d;
    logic        rd_q, rd_d;
    logic [12:0] addr_q, addr_d;
    logic        active, blank;

    always_comb begin
        next_vc = (vc_q == VC_LAST) ? 9'd0 : vc_q + 9'd1;
        hc_d    = hc_q + 9'd1;
        vc_d    = vc_q;
        if (hc_q == HC_LAST) begin
            hc_d = 9'd0;
            vc_d = next_vc;
        end

        active = (hc_q < 9'd256) && (vc_q < 9'd192);
        blank  = ((hc_q >= HB_S) && (hc_q < HB_E)) || ((vc_q >= VB_S) && (vc_q < VB_E));
        rgb_d  = border;
        if (blank) begin
            rgb_d = 9'd0;
        end else if (active) begin
            rgb_d = shift_q[7] ? ink : paper;
        end

        hs_d    = !((hc_q >= HS_S) && (hc_q < HS_E));
        vs_d    = !((vc_q >= VS_S) && (vc_q < VS_E));
        frame_d = (hc_q == 9'd0) && (vc_q == 9'd0);

        // Each byte is requested two pixels ahead of its group so it lands in the
        // shifter exactly as the previous group's last bit is consumed.
        grp    = 5'((hc_q + 9'd2) >> 3);
        rd_d   = 1'b0;
        addr_d = addr_q;
        if ((hc_q[2:0] == 3'd6) && (hc_q < 9'd254) && (vc_q < 9'd192)) begin
            rd_d   = 1'b1;
            addr_d = {vc_q[7:0], grp};
        end else if ((hc_q == HC_PRE) && (next_vc < 9'd192)) begin
            rd_d   = 1'b1;
            addr_d = {next_vc[7:0], 5'd0};
        end

        shift_d = rd_q ? fb_data : {shift_q[6:0], 1'b0};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hc_q    <= 9'd0;
            vc_q    <= 9'd0;
            shift_q <= 8'd0;
            rgb_q   <= 9'd0;
            hs_q    <= 1'b1;
            vs_q    <= 1'b1;
            frame_q <= 1'b0;
            rd_q    <= 1'b0;
            addr_q  <= 13'd0;
        end else begin
            hc_q    <= hc_d;
            vc_q    <= vc_d;
            shift_q <= shift_d;
            rgb_q   <= rgb_d;
            hs_q    <= hs_d;
            vs_q    <= vs_d;
            frame_q <= frame_d;
            rd_q    <= rd_d;
            addr_q  <= addr_d;
        end
    end

`ifdef CSYNC_EN
    logic cs_q, cs_d;

    assign cs_d = ~(hs_d ^ vs_d);

    always_ff @(posedge clk) begin
        if (rst) begin
            cs_q <= 1'b1;
        end else begin
            cs_q <= cs_d;
        end
    end

    assign csync_n = cs_q;
`endif

    assign ro      = rgb_q[8:6];
    assign go      = rgb_q[5:3];
    assign bo      = rgb_q[2:0];
    assign hsync_n = hs_q;
    assign vsync_n = vs_q;
    assign frame   = frame_q;
    assign fb_rd   = rd_q;
    assign fb_addr = addr_q;

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen: default-timing instance plus a short-frame instance for frame wrap.
module tb_video_timing_gen;

    typedef struct packed {
        int ht; int hbs; int hbe; int hss; int hsl;
        int vt; int vbs; int vbe; int vss; int vsl;
    } tim_t;

    localparam tim_t TA = '{ht:416, hbs:320, hbe:400, hss:336, hsl:32,
                            vt:312, vbs:248, vbe:264, vss:248, vsl:8};
    localparam tim_t TS = '{ht:272, hbs:260, hbe:270, hss:262, hsl:4,
                            vt:196, vbs:193, vbe:196, vss:193, vsl:2};

    logic        clk = 1'b0;
    logic        rst_a, rst_b;
    logic [8:0]  ink, paper, border;
    logic        fb_rd_a, fb_rd_b;
    logic [12:0] fb_addr_a, fb_addr_b;
    logic [7:0]  fb_data_a, fb_data_b;
    logic [2:0]  ro_a, go_a, bo_a, ro_b, go_b, bo_b;
    logic        hsync_a, vsync_a, frame_a, hsync_b, vsync_b, frame_b;
`ifdef CSYNC_EN
    logic        csync_a, csync_b;
`endif
    logic [7:0]  mem [8192];

    always #5 clk = ~clk;

    // Data only meaningful when strobed; otherwise the bus carries a decoy.
    assign fb_data_a = fb_rd_a ? mem[fb_addr_a] : ~mem[fb_addr_a];
    assign fb_data_b = fb_rd_b ? mem[fb_addr_b] : ~mem[fb_addr_b];

    video_timing_gen dut_a (
        .clk(clk), .rst(rst_a), .ink(ink), .paper(paper), .border(border),
        .fb_rd(fb_rd_a), .fb_addr(fb_addr_a), .fb_data(fb_data_a),
        .ro(ro_a), .go(go_a), .bo(bo_a),
        .hsync_n(hsync_a), .vsync_n(vsync_a), .frame(frame_a)
`ifdef CSYNC_EN
        , .csync_n(csync_a)
`endif
    );

    video_timing_gen #(
        .H_TOTAL(272), .H_BLANK_START(260), .H_BLANK_END(270), .H_SYNC_START(262), .H_SYNC_LEN(4),
        .V_TOTAL(196), .V_BLANK_START(193), .V_BLANK_END(196), .V_SYNC_START(193), .V_SYNC_LEN(2)
    ) dut_b (
        .clk(clk), .rst(rst_b), .ink(ink), .paper(paper), .border(border),
        .fb_rd(fb_rd_b), .fb_addr(fb_addr_b), .fb_data(fb_data_b),
        .ro(ro_b), .go(go_b), .bo(bo_b),
        .hsync_n(hsync_b), .vsync_n(vsync_b), .frame(frame_b)
`ifdef CSYNC_EN
        , .csync_n(csync_b)
`endif
    );

    int checks = 0, failures = 0;
    int edge_n = 0, cnt_a = 0, cnt_b = 0, phase = 0;
    logic [8:0] p_ink, p_paper, p_border;
    logic p_rst_a, p_rst_b;

    int a_fr[$], a_hs_fall[$], b_fr[$];
    int hs_low0 = 0, rd3 = 0, brd_ok = 0, blk_ok = 0, b_vs_low = 0, b_vs_fall = -1;
    logic prev_hs_a = 1'b1, prev_vs_b = 1'b1;
    logic b_rd_h1 = 1'b0, b_rd_h2 = 1'b0, b_pf_rd = 1'b0;
    logic [12:0] b_ad_h1 = 13'd0, b_ad_h2 = 13'd0, b_pf_ad = 13'h1FFF;
    logic [8:0] line5 [8];
    logic [8:0] pat [8] = '{9'h1FF, 9'h000, 9'h1FF, 9'h000, 9'h000, 9'h1FF, 9'h000, 9'h1FF};

    task automatic ck(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    // Expected output for the pixel at raster position cnt (counter cycles since reset).
    function automatic void model(input tim_t t, input int cnt, input logic [8:0] ik, pp, bd,
                                  output logic [8:0] rgb, output logic hs, vs, fr, rd,
                                  output logic [12:0] ad);
        int hc, vc, fn, nvc;
        logic [7:0] b;
        hc  = cnt % t.ht;
        vc  = (cnt / t.ht) % t.vt;
        fn  = cnt / (t.ht * t.vt);
        nvc = (vc + 1) % t.vt;
        if ((hc >= t.hbs && hc < t.hbe) || (vc >= t.vbs && vc < t.vbe)) begin
            rgb = 9'd0;
        end else if (hc < 256 && vc < 192) begin
            b = mem[13'(vc * 32 + hc / 8)];
            if (fn == 0 && vc == 0 && hc < 8) rgb = pp;
            else rgb = b[7 - (hc % 8)] ? ik : pp;
        end else begin
            rgb = bd;
        end
        hs = !(hc >= t.hss && hc < t.hss + t.hsl);
        vs = !(vc >= t.vss && vc < t.vss + t.vsl);
        fr = (hc == 0 && vc == 0);
        rd = 1'b0;
        ad = 13'd0;
        if (hc % 8 == 6 && hc < 254 && vc < 192) begin
            rd = 1'b1;
            ad = 13'(vc * 32 + (hc + 2) / 8);
        end else if (hc == t.ht - 2 && nvc < 192) begin
            rd = 1'b1;
            ad = 13'(nvc * 32);
        end
    endfunction

    task automatic cmp_dut(input string nm, input tim_t t, input logic prst, inout int cnt,
                           input logic [8:0] rgb, input logic hs, vs, fr, rd, input logic [12:0] ad
`ifdef CSYNC_EN
                           , input logic cs
`endif
                           );
        logic [8:0] e_rgb;
        logic e_hs, e_vs, e_fr, e_rd;
        logic [12:0] e_ad;
        if (prst) begin
            e_rgb = 9'd0; e_hs = 1'b1; e_vs = 1'b1; e_fr = 1'b0; e_rd = 1'b0; e_ad = 13'd0;
            cnt = 0;
        end else begin
            model(t, cnt, p_ink, p_paper, p_border, e_rgb, e_hs, e_vs, e_fr, e_rd, e_ad);
            cnt++;
        end
        ck({nm, ".rgb"}, 32'(rgb), 32'(e_rgb));
        ck({nm, ".hsync_n"}, 32'(hs), 32'(e_hs));
        ck({nm, ".vsync_n"}, 32'(vs), 32'(e_vs));
        ck({nm, ".frame"}, 32'(fr), 32'(e_fr));
        ck({nm, ".fb_rd"}, 32'(rd), 32'(e_rd));
        if (e_rd) ck({nm, ".fb_addr"}, 32'(ad), 32'(e_ad));
`ifdef CSYNC_EN
        ck({nm, ".csync_n"}, 32'(cs), 32'(~(e_hs ^ e_vs)));
`endif
    endtask

    task automatic tick();
        int hc, vc;
        logic [8:0] rgb;
        p_ink = ink; p_paper = paper; p_border = border; p_rst_a = rst_a; p_rst_b = rst_b;
        @(posedge clk);
        #1;
        edge_n++;
        hc  = cnt_a % 416;
        vc  = (cnt_a / 416) % 312;
        rgb = {ro_a, go_a, bo_a};
        if (!p_rst_a && phase == 0) begin
            if (vc == 5 && hc >= 24 && hc < 32) line5[hc - 24] = rgb;
            if (vc == 6 && hc >= 256 && hc < 320 && rgb === 9'h049) brd_ok++;
            if (vc == 6 && hc >= 320 && hc < 400 && rgb === 9'h000) blk_ok++;
            if (vc == 3 && fb_rd_a) rd3++;
            if (vc == 0 && !hsync_a) hs_low0++;
            if (prev_hs_a && !hsync_a) a_hs_fall.push_back(edge_n);
            if (frame_a) a_fr.push_back(edge_n);
        end
        prev_hs_a = hsync_a;
        cmp_dut("a", TA, p_rst_a, cnt_a, rgb, hsync_a, vsync_a, frame_a, fb_rd_a, fb_addr_a
`ifdef CSYNC_EN
                , csync_a
`endif
                );

        if (frame_b) begin
            b_fr.push_back(edge_n);
            if (b_fr.size() == 2) begin
                b_pf_rd = b_rd_h2;
                b_pf_ad = b_ad_h2;
            end
        end
        if (b_fr.size() == 1 && !vsync_b) b_vs_low++;
        if (b_fr.size() == 1 && prev_vs_b && !vsync_b) b_vs_fall = edge_n;
        prev_vs_b = vsync_b;
        b_rd_h2 = b_rd_h1; b_rd_h1 = fb_rd_b;
        b_ad_h2 = b_ad_h1; b_ad_h1 = fb_addr_b;
        cmp_dut("b", TS, p_rst_b, cnt_b, {ro_b, go_b, bo_b}, hsync_b, vsync_b, frame_b, fb_rd_b, fb_addr_b
`ifdef CSYNC_EN
                , csync_b
`endif
                );

        vc = (cnt_a / 416) % 312;
        if (phase == 0 && vc >= 4 && vc <= 7) begin
            ink = 9'h1FF; paper = 9'h000; border = 9'h049;
        end else begin
            ink = 9'($urandom); paper = 9'($urandom); border = 9'($urandom);
        end
    endtask

    initial begin
        int n;
        for (int i = 0; i < 8192; i++) mem[i] = 8'($urandom);
        mem[{8'd5, 5'd3}] = 8'hA5;
        for (int i = 0; i < 8; i++) line5[i] = 9'h0AA;
        ink = 9'($urandom); paper = 9'($urandom); border = 9'($urandom);
        rst_a = 1'b1;
        rst_b = 1'b1;
        repeat (3) tick();
        rst_a = 1'b0;
        rst_b = 1'b0;
        tick();
        ck("a.first_frame_after_reset", 32'(frame_a), 32'd1);
        ck("b.first_frame_after_reset", 32'(frame_b), 32'd1);

        repeat (8 * 416) tick();
        ck("a.frame_pulses_seen", a_fr.size(), 1);
        ck("a.hsync_falls_seen", 32'(a_hs_fall.size() >= 2), 32'd1);
        if (a_fr.size() >= 1 && a_hs_fall.size() >= 2) begin
            ck("a.hsync_start_offset", a_hs_fall[0] - a_fr[0] + 1, 337);
            ck("a.line_period", a_hs_fall[1] - a_hs_fall[0], 416);
        end
        ck("a.hsync_low_width", hs_low0, 32);
        ck("a.fb_rd_per_line", rd3, 32);
        for (int i = 0; i < 8; i++) ck($sformatf("a.line5_px%0d", 24 + i), 32'(line5[i]), 32'(pat[i]));
        ck("a.border_pixels", brd_ok, 64);
        ck("a.blank_pixels", blk_ok, 80);

        phase = 1;
        for (int i = 0; i < 30000 && cnt_a != 50 * 416 + 100; i++) tick();
        ck("a.reached_midline", cnt_a, 50 * 416 + 100);
        rst_a = 1'b1;
        tick();
        rst_a = 1'b0;
        tick();
        ck("a.restart_frame", 32'(frame_a), 32'd1);
        n = 32'(fb_rd_a);
        repeat (5) begin
            tick();
            n += 32'(fb_rd_a);
        end
        ck("a.no_fb_rd_after_restart", n, 0);

        for (int i = 0; i < 60000 && b_fr.size() < 2; i++) tick();
        ck("b.frame_pulses_seen", 32'(b_fr.size() >= 2), 32'd1);
        if (b_fr.size() >= 2) begin
            ck("b.frame_period", b_fr[1] - b_fr[0], 272 * 196);
            ck("b.vsync_low_cycles", b_vs_low, 2 * 272);
            ck("b.vsync_start_offset", b_vs_fall - b_fr[0], 193 * 272);
            ck("b.prefetch_rd", 32'(b_pf_rd), 32'd1);
            ck("b.prefetch_addr", 32'(b_pf_ad), 32'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/video_timing_gen.md
# video_timing_gen

Generates the native 15 kHz video stream (RGB333 plus active-low horizontal and vertical sync) that feeds the VGA scan doubler's `ri/gi/bi/hsync_ext_n/vsync_ext_n` inputs. It runs one pixel per clock. Horizontal and vertical counters drive a byte-wide bitmap framebuffer fetch, and an 8-bit pixel shifter turns each fetched byte into ink or paper pixels. Border and blanking are inserted around the 256x192 active window.

## Interface
Parameters:
- `H_TOTAL`, 416: pixels per line.
- `H_BLANK_START`, 320: first blanked column.
- `H_BLANK_END`, 400: first unblanked column after blanking.
- `H_SYNC_START`, 336: first column with `hsync_n` low.
- `H_SYNC_LEN`, 32: `hsync_n` low width, in pixels.
- `V_TOTAL`, 312: lines per frame.
- `V_BLANK_START`, 248: first blanked line.
- `V_BLANK_END`, 264: first unblanked line after blanking.
- `V_SYNC_START`, 248: first line with `vsync_n` low.
- `V_SYNC_LEN`, 8: `vsync_n` low width, in lines.

Ports:
- `clk` input 1: pixel clock. All logic is on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `ink` input 9: RGB333 `{r,g,b}` for set bits.
- `paper` input 9: RGB333 for clear bits.
- `border` input 9: RGB333 outside the active window.
- `fb_rd` output 1: framebuffer read strobe, one cycle wide.
- `fb_addr` output 13: `{line[7:0], group[4:0]}`.
- `fb_data` input 8: read data, valid the cycle after `fb_rd`.
- `ro`, `go`, `bo` output 3 each: registered colour.
- `hsync_n` output 1: registered horizontal sync.
- `vsync_n` output 1: registered vertical sync.
- `frame` output 1: one-cycle pulse aligned with output of pixel (0,0).
- `csync_n` output 1: present only with `CSYNC_EN`.

## Operation
- **Counters:** `hc` (9 bit) counts 0..`H_TOTAL`-1. At wrap, `vc` (9 bit) increments, counting 0..`V_TOTAL`-1 and then wrapping to 0.
- **Regions:**
  - Active: `hc`<256 and `vc`<192.
  - Blank: `hc` in [`H_BLANK_START`,`H_BLANK_END`) or `vc` in [`V_BLANK_START`,`V_BLANK_END`).
  - Border: everything else.
- **Fetch:** `fb_rd`=1 with `fb_addr`={`vc`[7:0],(`hc`+2)>>3} when `hc`[2:0]==6, `hc`<254 and `vc`<192.
- **Prefetch:** `fb_rd`=1 with `fb_addr`={next_vc[7:0],5'd0} when `hc`==`H_TOTAL`-2 and next_vc<192.
  - next_vc = `vc`+1, or 0 when `vc`==`V_TOTAL`-1.
- **Shifter load and shift:**
  - In the cycle after `fb_rd` (counter `hc`[2:0]==7), `fb_data` is loaded into `shift[7:0]` at that cycle's end.
  - Otherwise `shift` shifts left by one bit each cycle.
- **Colour select:**
  - Active: `shift[7]` ? `ink` : `paper`.
  - Border: `border`.
  - Blank: 0.
- **Sync:**
  - `hsync_n`=0 when `hc` is in [`H_SYNC_START`, `H_SYNC_START`+`H_SYNC_LEN`).
  - `vsync_n`=0 when `vc` is in [`V_SYNC_START`, `V_SYNC_START`+`V_SYNC_LEN`), for whole lines.
- **Input sampling:** `ink`, `paper` and `border` are sampled in the cycle the pixel is computed; no latching.
- **Reset:** on `rst`=1 at a clock edge:
  - `hc`=`vc`=0, `shift`=0.
  - `ro`=`go`=`bo`=0, `hsync_n`=`vsync_n`=1, `fb_rd`=0, `frame`=0.
- **After reset:** line 0 group 0 has not been prefetched, so the first 8 active pixels after reset are `paper`. Every later frame is correct.
- **Reset mid-line:** aborts the line immediately. An in-flight `fb_data` is discarded.

## Timing
- Colour, syncs and `frame` are registered with 1-cycle latency from the counter value that produced them, so all outputs stay mutually aligned.
- `fb_rd` and `fb_addr` are registered from the counter value and are high for exactly one cycle per fetch.
- The memory latency is fixed at 1 cycle; no wait states and no handshake back-pressure.
- Per active line: 32 fetches, 8 clocks apart. The first is issued 2 clocks before the line starts (previous line's `hc`=`H_TOTAL`-2).
- `frame`=1 in the output cycle carrying pixel `hc`=0, `vc`=0.
- Line period is `H_TOTAL` clocks and frame period is `H_TOTAL`*`V_TOTAL` clocks: 129792 at the defaults.

## Configuration
- `CSYNC_EN` defined: adds output `csync_n` = ~(`hsync_n` ^ `vsync_n`), registered with the same 1-cycle alignment.
  - Outside vsync it equals `hsync_n`.
  - During vsync it is the inverted `hsync_n`.
- `CSYNC_EN` undefined: the `csync_n` port and its logic are absent; all other behaviour is identical.

## Test plan
- **Reset values:** assert `rst` for 3 cycles.
  - Required: `ro`/`go`/`bo`=0, `hsync_n`=`vsync_n`=1 and `fb_rd`=0 throughout.
  - Required: first `frame` pulse exactly 1 cycle after `rst` deasserts.
- **Line timing:** free-run one line.
  - Required: `hsync_n` low for 32 cycles starting at output cycle 337 after line start.
  - Required: next line starts 416 cycles later.
  - Required: `fb_rd` count per active line = 32.
- **Fetch/pixel:** memory returns 8'hA5 at address {8'd5,5'd3}, with `ink`=9'h1FF and `paper`=9'h000.
  - Required: line 5, pixels 24..31 output 1FF,000,1FF,000,000,1FF,000,1FF.
- **Border/blank:** with `border`=9'h049, require output 049 at `hc`=256..319 and 000 at `hc`=320..399.
- **Frame wrap:** run 2 frames.
  - Required: `vsync_n` low for 8*416 cycles from line 248; `frame` period is 129792.
  - Required: prefetch at line 311 `hc`=414 with address 0.
- **Reset mid-line:** pulse `rst` at `hc`=100, `vc`=50.
  - Required: counters restart at 0 with no `fb_rd` for 6 cycles after release.
  - Required: with `CSYNC_EN`, `csync_n` equals ~(`hsync_n` ^ `vsync_n`) on every cycle.
